id_pipe: RTL
============

# id_pipe

Parametrised, registered successor to the St.PU instruction-decode stage. It decodes the current instruction and reads both source operands. It resolves them through NUM_FWD priority-ordered bypass channels and detects load-use hazards. It produces the ID/EX pipeline register behind a valid/ready handshake, so downstream back-pressure, flush and hazard bubbles are handled inside the stage. It sits between the IF/ID register and EX.

## Interface
- DATA_W, 32, datapath and register width
- REG_AW, 5, register-file address width
- NUM_FWD, 2, bypass channels; index 0 is youngest and highest priority
- STALL_CNT_W, 16, width of the saturating stall counter
- clk  in  1  clock; every register updates on the rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid / in_ready  in / out  1 / 1  instruction handshake from IF/ID
- pc_i, inst_i  in  DATA_W, 32  PC and instruction word
- reg1_addr_o, reg2_addr_o  out  REG_AW  register-file read addresses (rs, rt), combinational
- reg1_read_o, reg2_read_o  out  1  read enables, combinational
- reg1_data_i, reg2_data_i  in  DATA_W  register-file read data, same cycle
- fwd_wreg_i  in  NUM_FWD  per-channel write-enable
- fwd_wd_i  in  NUM_FWD*REG_AW  per-channel destination, channel i at [i*REG_AW +: REG_AW]
- fwd_wdata_i  in  NUM_FWD*DATA_W  per-channel result data
- fwd_pending_i  in  NUM_FWD  channel result not yet available (load in flight)
- flush_i  in  1  kill the input and the output slot
- out_valid / out_ready  out / in  1 / 1  ID/EX handshake
- aluop_o, alusel_o, wd_o, wreg_o  out  `AluOpBus, `AluSelBus, REG_AW, 1  registered decode results
- reg1_o, reg2_o, pc_o  out  DATA_W  registered operands and PC
- inst_invalid_o  out  1  registered flag: opcode or funct not recognised
- stallreq_o  out  1  combinational; in_valid && hazard
- stall_cnt_o  out  STALL_CNT_W  saturating count of stall cycles

## Operation
- Decode covers the existing St.PU subset.
  - SPECIAL: OR, AND, XOR, NOR, SLLV, SRLV, SRAV, ADD, SUB, ADDU, SUBU, SLT, SLTU, MULT, MULTU, MFHI, MFLO, MTHI, MTLO, DIV, DIVU.
  - SLL, SRL, SRA only when rs==0.
  - Immediate: ORI, ANDI, XORI, LUI, ADDI, ADDIU, SLTI, SLTIU.
- Immediate extension:
  - ANDI, ORI, XORI: zero-extended.
  - ADDI, ADDIU, SLTI, SLTIU: sign-extended. This corrects the former unsigned ADDIU/SLTIU.
  - LUI: {imm,16'h0}.
  - Shift amount: {27'h0,sa} onto reg1.
- Unrecognised encoding: NOP aluop/alusel, wreg=0, inst_invalid=1.
- Operand resolution applies to each enabled source with address ≠ 0. The lowest channel i with fwd_wreg_i[i] && fwd_wd_i[i]==addr wins.
  - If fwd_pending_i[i] is set, a hazard is raised.
  - Otherwise the operand takes fwd_wdata_i[i].
  - With no match, the operand takes the register-file data.
- Address 0 is never forwarded and reads as 0. A disabled source takes the immediate.
- hazard = OR of the hazards on both sources.
- in_ready = rst && !flush_i && !hazard && (!out_valid || out_ready).
- Output register loads when rst && (!out_valid || out_ready):
  - accept (in_valid && in_ready): loads the decode, out_valid<=1;
  - otherwise out_valid<=0, giving a bubble.
- flush_i has priority over everything except reset. The next cycle out_valid<=0, and the input is not accepted.
- stall_cnt_o increments when in_valid && !in_ready && !flush_i, and saturates at all-ones.

## Timing
- Latency is 1 cycle from acceptance to out_valid.
- Decode, forwarding and hazard detection are combinational within the accept cycle.
- Stall (out_valid && !out_ready): all registered outputs hold, and in_ready=0.
- Hazard with a free slot: a bubble is inserted. The instruction is re-presented by upstream, because stallreq_o holds PC.
- Hazard and out_ready=0 together: the output holds, because back-pressure dominates.
- Reset (rst==0 at an edge), including mid-operation, forces:
  - out_valid=0, aluop=`EXE_NOP_OP, alusel=`EXE_RES_NOP, wd=`NOPRegAddr;
  - wreg=0, reg1/reg2/pc=`ZeroWord, inst_invalid=0, stall_cnt=0;
  - in_ready=0 during reset.

## Structure
- Defines.vh gains `EXE_ADDIU/`EXE_SLTIU immediate-extension selectors and `NOPRegAddr, reused as-is.
- The new parameters stay module-local.
- Sub-module id_fwd_mux, parametrised by NUM_FWD, DATA_W and REG_AW. It is instanced once per operand and returns the operand value plus a hazard bit.
- The decode case statement stays in id_pipe.

## Test plan
- ORI $2,$1,0x8000 with reg1_data=0x0000_00F0 and no forwarding: next cycle out_valid=1, reg1=0xF0, reg2=0x0000_8000, wd=2, wreg=1.
- ADD $3,$1,$2 with channel0 {wd=1, 0x11} and channel1 {wd=1, 0x22}, reg2_data=5: reg1=0x11, because channel 0 wins; reg2=5.
- ADDIU $4,$0,0xFFFF: reg1=0, reg2=0xFFFF_FFFF. Also, forwarding with fwd_wd=0 and fwd_wreg=1 is ignored: reg1 stays 0.
- Load-use: channel0 {wd=1, pending=1} with OR $5,$1,$2 presented 3 cycles:
  - in_ready=0, stallreq_o=1, out_valid=0 and stall_cnt increments by 3;
  - after pending drops, the instruction issues with the channel data.
- out_ready=0 for 4 cycles with a valid output: outputs are stable and in_ready=0. Then flush_i for 1 cycle: out_valid=0 next cycle and the input is discarded.
- rst=0 asserted while out_valid=1: next edge returns all outputs to reset values. stall_cnt forced to 0xFFFF by stalling saturates without wrap.

Source files
------------

// File: rtl/id_pipe_pkg.sv
// Shared decode constants for the registered instruction-decode stage.
// Encodings follow the St.PU MIPS subset and its ALU operation codes.
package id_pipe_pkg;

  localparam int ALU_OP_W  = 8;
  localparam int ALU_SEL_W = 3;

  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_ZERO,
    IMM_SIGN,
    IMM_LUI,
    IMM_SA
  } imm_kind_e;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;

  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  localparam logic [7:0] EXE_NOP_OP   = 8'h00;
  localparam logic [7:0] EXE_AND_OP   = 8'h24;
  localparam logic [7:0] EXE_OR_OP    = 8'h25;
  localparam logic [7:0] EXE_XOR_OP   = 8'h26;
  localparam logic [7:0] EXE_NOR_OP   = 8'h27;
  localparam logic [7:0] EXE_SLL_OP   = 8'h7C;
  localparam logic [7:0] EXE_SRL_OP   = 8'h02;
  localparam logic [7:0] EXE_SRA_OP   = 8'h03;
  localparam logic [7:0] EXE_ADD_OP   = 8'h20;
  localparam logic [7:0] EXE_ADDU_OP  = 8'h21;
  localparam logic [7:0] EXE_SUB_OP   = 8'h22;
  localparam logic [7:0] EXE_SUBU_OP  = 8'h23;
  localparam logic [7:0] EXE_SLT_OP   = 8'h2A;
  localparam logic [7:0] EXE_SLTU_OP  = 8'h2B;
  localparam logic [7:0] EXE_ADDI_OP  = 8'h55;
  localparam logic [7:0] EXE_ADDIU_OP = 8'h56;
  localparam logic [7:0] EXE_MULT_OP  = 8'h18;
  localparam logic [7:0] EXE_MULTU_OP = 8'h19;
  localparam logic [7:0] EXE_DIV_OP   = 8'h1A;
  localparam logic [7:0] EXE_DIVU_OP  = 8'h1B;
  localparam logic [7:0] EXE_MFHI_OP  = 8'h10;
  localparam logic [7:0] EXE_MTHI_OP  = 8'h11;
  localparam logic [7:0] EXE_MFLO_OP  = 8'h12;
  localparam logic [7:0] EXE_MTLO_OP  = 8'h13;

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;
  localparam logic [2:0] RES_ARITH = 3'b100;

endpackage

// File: rtl/id_fwd_mux.sv
// Operand resolution for one source: immediate, $0, bypass channels
// (lowest index wins) or register file, plus a load-use hazard flag.
module id_fwd_mux #(
  parameter int NUM_FWD = 2,
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5
) (
  input  logic                      en,
  input  logic [REG_AW-1:0]         addr,
  input  logic [DATA_W-1:0]         rf_data,
  input  logic [DATA_W-1:0]         imm,
  input  logic [NUM_FWD-1:0]        fwd_wreg,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wd,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  output logic [DATA_W-1:0]         data,
  output logic                      hazard
);

  always_comb begin
    data   = rf_data;
    hazard = 1'b0;
    if (!en) begin
      data = imm;
    end else if (addr == '0) begin
      data = '0;
    end else begin
      // walk oldest to youngest so the youngest match is applied last
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (fwd_wreg[i] && fwd_wd[i*REG_AW +: REG_AW] == addr) begin
          data   = fwd_wdata[i*DATA_W +: DATA_W];
          hazard = fwd_pending[i];
        end
      end
    end
  end

endmodule

// File: rtl/id_pipe.sv
// Registered decode stage: decode, operand bypass, load-use detection
// and the ID/EX slot behind a valid/ready handshake.
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int NUM_FWD     = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         pc_i,
  input  logic [31:0]               inst_i,
  output logic [REG_AW-1:0]         reg1_addr_o,
  output logic [REG_AW-1:0]         reg2_addr_o,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]        fwd_pending_i,
  input  logic                      flush_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ALU_OP_W-1:0]       aluop_o,
  output logic [ALU_SEL_W-1:0]      alusel_o,
  output logic [REG_AW-1:0]         wd_o,
  output logic                      wreg_o,
  output logic [DATA_W-1:0]         reg1_o,
  output logic [DATA_W-1:0]         reg2_o,
  output logic [DATA_W-1:0]         pc_o,
  output logic                      inst_invalid_o,
  output logic                      stallreq_o,
  output logic [STALL_CNT_W-1:0]    stall_cnt_o
);

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign fn    = inst_i[5:0];
  assign imm16 = inst_i[15:0];

  logic [ALU_OP_W-1:0]  d_aluop;
  logic [ALU_SEL_W-1:0] d_sel;
  logic                 d_wreg, d_r1, d_r2, d_inv;
  imm_kind_e            d_ik;
  logic [REG_AW-1:0]    d_wd;
  logic [DATA_W-1:0]    d_imm;

  always_comb begin
    d_aluop = EXE_NOP_OP;
    d_sel   = RES_NOP;
    d_wreg  = 1'b1;
    d_r1    = 1'b1;
    d_r2    = 1'b0;
    d_ik    = IMM_NONE;
    d_inv   = 1'b0;
    case (op)
      OP_SPECIAL: begin
        d_r2 = 1'b1;
        case (fn)
          F_OR:    begin d_aluop = EXE_OR_OP;   d_sel = RES_LOGIC; end
          F_AND:   begin d_aluop = EXE_AND_OP;  d_sel = RES_LOGIC; end
          F_XOR:   begin d_aluop = EXE_XOR_OP;  d_sel = RES_LOGIC; end
          F_NOR:   begin d_aluop = EXE_NOR_OP;  d_sel = RES_LOGIC; end
          F_SLLV:  begin d_aluop = EXE_SLL_OP;  d_sel = RES_SHIFT; end
          F_SRLV:  begin d_aluop = EXE_SRL_OP;  d_sel = RES_SHIFT; end
          F_SRAV:  begin d_aluop = EXE_SRA_OP;  d_sel = RES_SHIFT; end
          F_ADD:   begin d_aluop = EXE_ADD_OP;  d_sel = RES_ARITH; end
          F_ADDU:  begin d_aluop = EXE_ADDU_OP; d_sel = RES_ARITH; end
          F_SUB:   begin d_aluop = EXE_SUB_OP;  d_sel = RES_ARITH; end
          F_SUBU:  begin d_aluop = EXE_SUBU_OP; d_sel = RES_ARITH; end
          F_SLT:   begin d_aluop = EXE_SLT_OP;  d_sel = RES_ARITH; end
          F_SLTU:  begin d_aluop = EXE_SLTU_OP; d_sel = RES_ARITH; end
          F_MULT:  begin d_aluop = EXE_MULT_OP;  d_wreg = 1'b0; end
          F_MULTU: begin d_aluop = EXE_MULTU_OP; d_wreg = 1'b0; end
          F_DIV:   begin d_aluop = EXE_DIV_OP;   d_wreg = 1'b0; end
          F_DIVU:  begin d_aluop = EXE_DIVU_OP;  d_wreg = 1'b0; end
          F_MFHI: begin
            d_aluop = EXE_MFHI_OP; d_sel = RES_MOVE;
            d_r1 = 1'b0; d_r2 = 1'b0;
          end
          F_MFLO: begin
            d_aluop = EXE_MFLO_OP; d_sel = RES_MOVE;
            d_r1 = 1'b0; d_r2 = 1'b0;
          end
          F_MTHI: begin d_aluop = EXE_MTHI_OP; d_wreg = 1'b0; d_r2 = 1'b0; end
          F_MTLO: begin d_aluop = EXE_MTLO_OP; d_wreg = 1'b0; d_r2 = 1'b0; end
          F_SLL: begin
            d_aluop = EXE_SLL_OP; d_sel = RES_SHIFT;
            d_r1 = 1'b0; d_ik = IMM_SA; d_inv = (rs != 5'd0);
          end
          F_SRL: begin
            d_aluop = EXE_SRL_OP; d_sel = RES_SHIFT;
            d_r1 = 1'b0; d_ik = IMM_SA; d_inv = (rs != 5'd0);
          end
          F_SRA: begin
            d_aluop = EXE_SRA_OP; d_sel = RES_SHIFT;
            d_r1 = 1'b0; d_ik = IMM_SA; d_inv = (rs != 5'd0);
          end
          default: d_inv = 1'b1;
        endcase
      end
      OP_ORI:   begin d_aluop = EXE_OR_OP;    d_sel = RES_LOGIC; d_ik = IMM_ZERO; end
      OP_ANDI:  begin d_aluop = EXE_AND_OP;   d_sel = RES_LOGIC; d_ik = IMM_ZERO; end
      OP_XORI:  begin d_aluop = EXE_XOR_OP;   d_sel = RES_LOGIC; d_ik = IMM_ZERO; end
      OP_LUI:   begin d_aluop = EXE_OR_OP;    d_sel = RES_LOGIC; d_ik = IMM_LUI;  end
      OP_ADDI:  begin d_aluop = EXE_ADDI_OP;  d_sel = RES_ARITH; d_ik = IMM_SIGN; end
      OP_ADDIU: begin d_aluop = EXE_ADDIU_OP; d_sel = RES_ARITH; d_ik = IMM_SIGN; end
      OP_SLTI:  begin d_aluop = EXE_SLT_OP;   d_sel = RES_ARITH; d_ik = IMM_SIGN; end
      OP_SLTIU: begin d_aluop = EXE_SLTU_OP;  d_sel = RES_ARITH; d_ik = IMM_SIGN; end
      default:  d_inv = 1'b1;
    endcase
    if (d_inv) begin
      d_aluop = EXE_NOP_OP;
      d_sel   = RES_NOP;
      d_wreg  = 1'b0;
      d_r1    = 1'b0;
      d_r2    = 1'b0;
      d_ik    = IMM_NONE;
    end
  end

  assign d_wd = d_inv ? REG_AW'(NOP_REG_ADDR)
                      : (op == OP_SPECIAL) ? REG_AW'(rd) : REG_AW'(rt);

  always_comb begin
    unique case (d_ik)
      IMM_ZERO: d_imm = DATA_W'(imm16);
      IMM_SIGN: d_imm = DATA_W'($signed(imm16));
      IMM_LUI:  d_imm = DATA_W'({imm16, 16'h0000});
      IMM_SA:   d_imm = DATA_W'(sa);
      default:  d_imm = '0;
    endcase
  end

  assign reg1_addr_o = REG_AW'(rs);
  assign reg2_addr_o = REG_AW'(rt);
  assign reg1_read_o = d_r1;
  assign reg2_read_o = d_r2;

  logic [DATA_W-1:0] op1, op2;
  logic              hz1, hz2, hazard, slot_free, accept;

  id_fwd_mux #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd1 (
    .en(d_r1), .addr(reg1_addr_o), .rf_data(reg1_data_i), .imm(d_imm),
    .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i), .fwd_wdata(fwd_wdata_i),
    .fwd_pending(fwd_pending_i), .data(op1), .hazard(hz1)
  );

  id_fwd_mux #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd2 (
    .en(d_r2), .addr(reg2_addr_o), .rf_data(reg2_data_i), .imm(d_imm),
    .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i), .fwd_wdata(fwd_wdata_i),
    .fwd_pending(fwd_pending_i), .data(op2), .hazard(hz2)
  );

  assign hazard     = hz1 | hz2;
  assign stallreq_o = in_valid && hazard;
  assign slot_free  = !out_valid || out_ready;
  assign in_ready   = rst && !flush_i && !hazard && slot_free;
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid      <= 1'b0;
      aluop_o        <= EXE_NOP_OP;
      alusel_o       <= RES_NOP;
      wd_o           <= REG_AW'(NOP_REG_ADDR);
      wreg_o         <= 1'b0;
      reg1_o         <= '0;
      reg2_o         <= '0;
      pc_o           <= '0;
      inst_invalid_o <= 1'b0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
    end else if (slot_free) begin
      out_valid <= accept;
      if (accept) begin
        aluop_o        <= d_aluop;
        alusel_o       <= d_sel;
        wd_o           <= d_wd;
        wreg_o         <= d_wreg;
        reg1_o         <= op1;
        reg2_o         <= op2;
        pc_o           <= pc_i;
        inst_invalid_o <= d_inv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_o <= '0;
    end else if (in_valid && !in_ready && !flush_i && !(&stall_cnt_o)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule
